// File: rtl/dpd_pkg.sv
// Shared types and Densely-Packed-Decimal conversion helpers for the DPD codec.
// Bit naming follows Cowlishaw: DPD = p q r s t u v w x y, BCD digits = abcd efgh ijkm.
package dpd_pkg;

  typedef logic [11:0] bcd3_t;
  typedef logic [9:0]  dpd_t;

  typedef enum logic {
    DPD_DEC = 1'b0,
    DPD_ENC = 1'b1
  } dpd_mode_e;

  // s,t,v,w,x all set selects the "three large digits" row where p,q are unused
  localparam dpd_t DPD_NC_MASK = 10'b00_0110_1110;
  localparam dpd_t DPD_PQ_MASK = 10'b11_0000_0000;

  function automatic logic dpd_noncanon(input dpd_t d);
    return ((d & DPD_NC_MASK) == DPD_NC_MASK) && ((d & DPD_PQ_MASK) != 10'h000);
  endfunction

  function automatic logic bcd_invalid(input bcd3_t b);
    return (b[11:8] > 4'd9) || (b[7:4] > 4'd9) || (b[3:0] > 4'd9);
  endfunction

  function automatic bcd3_t dpd_decode(input dpd_t d);
    bcd3_t b;
    b = 12'h000;
    if (d[3] == 1'b0) begin
      b = {1'b0, d[9:7], 1'b0, d[6:4], 1'b0, d[2:0]};
    end else begin
      case (d[2:1])
        2'b00:   b = {1'b0, d[9:7], 1'b0, d[6:4], 3'b100, d[0]};
        2'b01:   b = {1'b0, d[9:7], 3'b100, d[4], 1'b0, d[6:5], d[0]};
        2'b10:   b = {3'b100, d[7], 1'b0, d[6:4], 1'b0, d[9:8], d[0]};
        2'b11: begin
          case (d[6:5])
            2'b00:   b = {3'b100, d[7], 3'b100, d[4], 1'b0, d[9:8], d[0]};
            2'b01:   b = {3'b100, d[7], 1'b0, d[9:8], d[4], 3'b100, d[0]};
            2'b10:   b = {1'b0, d[9:7], 3'b100, d[4], 3'b100, d[0]};
            2'b11:   b = {3'b100, d[7], 3'b100, d[4], 3'b100, d[0]};
            default: b = 12'h000;
          endcase
        end
        default: b = 12'h000;
      endcase
    end
    return b;
  endfunction

  // Row selected by the MSBs (a,e,i) of the three digits
  function automatic dpd_t dpd_encode(input bcd3_t b);
    dpd_t r;
    r = 10'h000;
    case ({b[11], b[7], b[3]})
      3'b000:  r = {b[10:8], b[6:4], 1'b0, b[2:0]};
      3'b001:  r = {b[10:8], b[6:4], 3'b100, b[0]};
      3'b010:  r = {b[10:8], b[2:1], b[4], 3'b101, b[0]};
      3'b011:  r = {b[10:8], 2'b10, b[4], 3'b111, b[0]};
      3'b100:  r = {b[2:1], b[8], b[6:4], 3'b110, b[0]};
      3'b101:  r = {b[6:5], b[8], 2'b01, b[4], 3'b111, b[0]};
      3'b110:  r = {b[2:1], b[8], 2'b00, b[4], 3'b111, b[0]};
      3'b111:  r = {2'b00, b[8], 2'b11, b[4], 3'b111, b[0]};
      default: r = 10'h000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dpd_codec_digit.sv
// Combinational single-declet codec: DPD->BCD decode or BCD->DPD encode.
module dpd_codec_digit
  import dpd_pkg::*;
(
  input  dpd_mode_e mode,
  input  bcd3_t     din,
  output bcd3_t     dout,
  output logic      err
);

  // Convert one declet; an invalid BCD digit blanks the whole declet
  always_comb begin
    dout = 12'h000;
    err  = 1'b0;
    case (mode)
      DPD_DEC: begin
        dout = dpd_decode(din[9:0]);
        err  = dpd_noncanon(din[9:0]);
      end
      DPD_ENC: begin
        if (bcd_invalid(din)) begin
          dout = 12'h000;
          err  = 1'b1;
        end else begin
          dout = {2'b00, dpd_encode(din)};
          err  = 1'b0;
        end
      end
      default: begin
        dout = 12'h000;
        err  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/dpd_codec_stream.sv
// Streaming N-declet DPD codec with a one- or two-stage elastic valid/ready pipeline
// and a sticky error flag covering every beat handed downstream.
module dpd_codec_stream
  import dpd_pkg::*;
#(
  parameter int N     = 11,
  parameter int PIPE2 = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_mode,
  input  logic [N*12-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_mode,
  output logic [N*12-1:0] out_data,
  output logic [N-1:0]    out_err,
  output logic            err_sticky,
  input  logic            clr_err
);

  localparam int W = N * 12;

  logic [W-1:0] conv_data_s;
  logic [N-1:0] conv_err_s;
  logic         in_ready_s;
  logic         s1_ready_s;
  logic         out_xfer_s;

  logic         ready_en_q, ready_en_d;
  logic         v0_q, v0_d;
  logic         mode0_q, mode0_d;
  logic [W-1:0] data0_q, data0_d;
  logic [N-1:0] err0_q, err0_d;
  logic         sticky_q, sticky_d;

  for (genvar g = 0; g < N; g++) begin : g_digit
    bcd3_t din_s;
    assign din_s = (in_mode == 1'b1) ? in_data[12*g +: 12] : {2'b00, in_data[10*g +: 10]};
    dpd_codec_digit u_digit (
      .mode (dpd_mode_e'(in_mode)),
      .din  (din_s),
      .dout (conv_data_s[12*g +: 12]),
      .err  (conv_err_s[g])
    );
  end

  // ready_en_q holds in_ready low until the first clock after reset release
  assign in_ready_s = ready_en_q & (~v0_q | s1_ready_s);
  assign in_ready   = in_ready_s;
  assign out_xfer_s = out_valid & out_ready;
  assign err_sticky = sticky_q;

  // Stage 0 next state: capture converted beat on input transfer
  always_comb begin
    ready_en_d = 1'b1;
    v0_d       = v0_q;
    mode0_d    = mode0_q;
    data0_d    = data0_q;
    err0_d     = err0_q;
    if (in_ready_s) begin
      v0_d = in_valid;
      if (in_valid) begin
        mode0_d = in_mode;
        data0_d = conv_data_s;
        err0_d  = conv_err_s;
      end else begin
        mode0_d = mode0_q;
        data0_d = data0_q;
        err0_d  = err0_q;
      end
    end else begin
      v0_d = v0_q;
    end
  end

  // Sticky error: a set in the same cycle as a clear wins
  always_comb begin
    sticky_d = sticky_q;
    if (out_xfer_s && (|out_err)) begin
      sticky_d = 1'b1;
    end else if (clr_err) begin
      sticky_d = 1'b0;
    end else begin
      sticky_d = sticky_q;
    end
  end

  // Stage 0, ready enable and sticky flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_q <= 1'b0;
      v0_q       <= 1'b0;
      mode0_q    <= 1'b0;
      data0_q    <= '0;
      err0_q     <= '0;
      sticky_q   <= 1'b0;
    end else begin
      ready_en_q <= ready_en_d;
      v0_q       <= v0_d;
      mode0_q    <= mode0_d;
      data0_q    <= data0_d;
      err0_q     <= err0_d;
      sticky_q   <= sticky_d;
    end
  end

  if (PIPE2 != 0) begin : g_pipe2
    logic         v1_q, v1_d;
    logic         mode1_q, mode1_d;
    logic [W-1:0] data1_q, data1_d;
    logic [N-1:0] err1_q, err1_d;

    assign s1_ready_s = ~v1_q | out_ready;

    // Stage 1 next state: take stage 0 whenever the output slot frees up
    always_comb begin
      v1_d    = v1_q;
      mode1_d = mode1_q;
      data1_d = data1_q;
      err1_d  = err1_q;
      if (s1_ready_s) begin
        v1_d = v0_q;
        if (v0_q) begin
          mode1_d = mode0_q;
          data1_d = data0_q;
          err1_d  = err0_q;
        end else begin
          mode1_d = mode1_q;
          data1_d = data1_q;
          err1_d  = err1_q;
        end
      end else begin
        v1_d = v1_q;
      end
    end

    // Stage 1 registers drive the outputs directly
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v1_q    <= 1'b0;
        mode1_q <= 1'b0;
        data1_q <= '0;
        err1_q  <= '0;
      end else begin
        v1_q    <= v1_d;
        mode1_q <= mode1_d;
        data1_q <= data1_d;
        err1_q  <= err1_d;
      end
    end

    assign out_valid = v1_q;
    assign out_mode  = mode1_q;
    assign out_data  = data1_q;
    assign out_err   = err1_q;
  end else begin : g_pipe1
    assign s1_ready_s = out_ready;
    assign out_valid  = v0_q;
    assign out_mode   = mode0_q;
    assign out_data   = data0_q;
    assign out_err    = err0_q;
  end

endmodule

// File: tb/tb_dpd_codec_stream.sv
// Scoreboard bench for dpd_codec_stream (N=11, PIPE2=1): directed codec cases,
// full-rate round trip, random backpressure and asynchronous reset mid-stream.
module tb_dpd_codec_stream;

  localparam int N = 11;
  localparam int W = N * 12;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, in_mode;
  logic         out_valid, out_ready, out_mode, err_sticky, clr_err;
  logic [W-1:0] in_data, out_data;
  logic [N-1:0] out_err;

  always #5 clk = ~clk;

  dpd_codec_stream #(.N(N), .PIPE2(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_mode(out_mode), .out_data(out_data), .out_err(out_err),
    .err_sticky(err_sticky), .clr_err(clr_err)
  );

  typedef struct {
    logic         mode;
    logic [W-1:0] data;
    logic [N-1:0] err;
    int           cyc;
  } beat_t;

  beat_t        sb[$];
  beat_t        cur;
  int           n_cmp = 0;
  int           n_bad = 0;
  int           cyc = 0;
  bit           chk_rdy = 1'b0, lat_chk = 1'b0, rnd_rdy = 1'b0;
  bit           last_in_xfer = 1'b0, stall_prev = 1'b0;
  logic [W-1:0] prev_data;
  logic [N-1:0] prev_err;
  logic         prev_mode;
  logic [11:0]  dec_tab [1024];
  bit           dec_can [1024];
  bit           dec_nc  [1024];
  logic         rm;
  logic [W-1:0] rd, ed, bd;
  logic [N-1:0] ee;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [W-1:0] lo12(input logic [11:0] v);
    return {{(W-12){1'b0}}, v};
  endfunction

  // Reference encoder, written per hundreds/tens/ones digit
  function automatic logic [9:0] ref_enc(input logic [11:0] b);
    logic [3:0] h, t, o;
    logic [9:0] r;
    h = b[11:8]; t = b[7:4]; o = b[3:0];
    case ({h[3], t[3], o[3]})
      3'b000:  r = {h[2:0], t[2:0], 1'b0, o[2:0]};
      3'b001:  r = {h[2:0], t[2:0], 3'b100, o[0]};
      3'b010:  r = {h[2:0], o[2:1], t[0], 3'b101, o[0]};
      3'b011:  r = {h[2:0], 2'b10, t[0], 3'b111, o[0]};
      3'b100:  r = {o[2:1], h[0], t[2:0], 3'b110, o[0]};
      3'b101:  r = {t[2:1], h[0], 2'b01, t[0], 3'b111, o[0]};
      3'b110:  r = {o[2:1], h[0], 2'b00, t[0], 3'b111, o[0]};
      default: r = {2'b00, h[0], 2'b11, t[0], 3'b111, o[0]};
    endcase
    return r;
  endfunction

  function automatic void model(input logic m, input logic [W-1:0] d,
                                output logic [W-1:0] od, output logic [N-1:0] oe);
    logic [11:0] b;
    logic [9:0]  c;
    od = '0; oe = '0;
    for (int g = 0; g < N; g++) begin
      if (m) begin
        b = d[12*g +: 12];
        if (b[11:8] > 4'd9 || b[7:4] > 4'd9 || b[3:0] > 4'd9) oe[g] = 1'b1;
        else od[12*g +: 12] = {2'b00, ref_enc(b)};
      end else begin
        c = d[10*g +: 10];
        od[12*g +: 12] = dec_tab[c];
        oe[g] = dec_nc[c];
      end
    end
  endfunction

  // One clock: check at negedge, push accepted beat, return at posedge+1
  task automatic step();
    beat_t e;
    if (rnd_rdy) out_ready = ($urandom_range(0, 1) == 1);
    @(negedge clk);
    cyc++;
    if (chk_rdy) chk("in_ready", W'(in_ready), W'(!(sb.size() >= 2 && !out_ready)));
    if (stall_prev) begin
      chk("stall_valid", W'(out_valid), W'(1'b1));
      chk("stall_data", out_data, prev_data);
      chk("stall_err", W'(out_err), W'(prev_err));
      chk("stall_mode", W'(out_mode), W'(prev_mode));
    end
    if (sb.size() == 0) begin
      chk("idle_out_valid", W'(out_valid), W'(1'b0));
    end else if (out_valid && out_ready) begin
      e = sb.pop_front();
      chk("out_data", out_data, e.data);
      chk("out_err", W'(out_err), W'(e.err));
      chk("out_mode", W'(out_mode), W'(e.mode));
      if (lat_chk) chk("latency", W'(cyc - e.cyc), W'(2));
    end
    last_in_xfer = in_valid && in_ready;
    if (last_in_xfer) begin
      cur.cyc = cyc;
      sb.push_back(cur);
    end
    stall_prev = out_valid && !out_ready;
    prev_data = out_data; prev_err = out_err; prev_mode = out_mode;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic m, input logic [W-1:0] d, input logic [W-1:0] xd,
                      input logic [N-1:0] xe);
    int n;
    in_valid = 1'b1; in_mode = m; in_data = d;
    cur.mode = m; cur.data = xd; cur.err = xe;
    n = 0;
    do begin
      step();
      n++;
    end while (!last_in_xfer && n < 100);
    chk("accept", W'(last_in_xfer), W'(1'b1));
  endtask

  task automatic send_model(input logic m, input logic [W-1:0] d);
    logic [W-1:0] xd;
    logic [N-1:0] xe;
    model(m, d, xd, xe);
    send(m, d, xd, xe);
  endtask

  task automatic drain(input int budget);
    in_valid = 1'b0;
    for (int i = 0; i < budget && sb.size() != 0; i++) step();
    chk("drain_empty", W'(sb.size()), W'(0));
  endtask

  initial begin
    for (int c = 0; c < 1024; c++) begin dec_can[c] = 1'b0; dec_nc[c] = 1'b0; end
    for (int v = 0; v < 1000; v++) begin
      dec_tab[ref_enc(to_bcd(v))] = to_bcd(v);
      dec_can[ref_enc(to_bcd(v))] = 1'b1;
    end
    for (int c = 0; c < 1024; c++) begin
      if (!dec_can[c]) begin
        dec_tab[c] = dec_tab[c & 10'h0FF];
        dec_nc[c]  = 1'b1;
      end
    end

    rst_n = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_data = '0;
    out_ready = 1'b1; clr_err = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", W'(out_valid), W'(1'b0));
    chk("rst_out_data", out_data, '0);
    chk("rst_out_err", W'(out_err), W'(0));
    chk("rst_out_mode", W'(out_mode), W'(1'b0));
    chk("rst_sticky", W'(err_sticky), W'(1'b0));
    chk("rst_in_ready", W'(in_ready), W'(1'b0));
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("ready_at_release", W'(in_ready), W'(1'b0));
    @(posedge clk); #1;
    chk("ready_after_release", W'(in_ready), W'(1'b1));
    chk_rdy = 1'b1;

    // Directed decode and encode
    send(1'b0, lo12(12'h0A3), lo12(12'h123), 11'h000);
    send(1'b0, lo12(12'h0FF), lo12(12'h999), 11'h000);
    send(1'b0, lo12(12'h000), lo12(12'h000), 11'h000);
    send(1'b1, lo12(12'h123), lo12(12'h0A3), 11'h000);
    send(1'b1, lo12(12'h999), lo12(12'h0FF), 11'h000);
    drain(20);
    chk("sticky_clean", W'(err_sticky), W'(1'b0));
    send(1'b1, lo12(12'h9A5), lo12(12'h000), 11'h001);
    drain(20);
    chk("sticky_enc_err", W'(err_sticky), W'(1'b1));
    clr_err = 1'b1; step(); clr_err = 1'b0;
    chk("sticky_cleared", W'(err_sticky), W'(1'b0));

    // Non-canonical decode, then a clear colliding with an erroring transfer
    send(1'b0, lo12(12'h3FF), lo12(12'h999), 11'h001);
    drain(20);
    chk("sticky_noncanon", W'(err_sticky), W'(1'b1));
    clr_err = 1'b1; step(); clr_err = 1'b0;
    chk("sticky_cleared2", W'(err_sticky), W'(1'b0));
    out_ready = 1'b0;
    send(1'b0, lo12(12'h16E), lo12(12'h888), 11'h001);
    in_valid = 1'b0;
    for (int i = 0; i < 5 && !out_valid; i++) step();
    out_ready = 1'b1; clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("sticky_set_wins", W'(err_sticky), W'(1'b1));
    drain(20);

    // Full-rate round trip, alternating encode/decode every beat
    lat_chk = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      for (int g = 0; g < N; g++) begin
        bd[12*g +: 12] = to_bcd((k + 97 * g) % 1000);
      end
      rd = '0;
      for (int g = 0; g < N; g++) rd[10*g +: 10] = ref_enc(bd[12*g +: 12]);
      send_model(1'b1, bd);
      send(1'b0, rd, bd, '0);
    end
    drain(20);
    lat_chk = 1'b0;

    // Random backpressure, random modes and data
    rnd_rdy = 1'b1;
    for (int b = 0; b < 200; b++) begin
      if ($urandom_range(0, 3) == 0) begin in_valid = 1'b0; step(); end
      rm = 1'($urandom_range(0, 1));
      for (int g = 0; g < N; g++) begin
        if (rm && $urandom_range(0, 15) != 0) rd[12*g +: 12] = to_bcd(int'($urandom_range(0, 999)));
        else rd[12*g +: 12] = 12'($urandom_range(0, 4095));
      end
      send_model(rm, rd);
    end
    drain(400);
    rnd_rdy = 1'b0; out_ready = 1'b1;

    // Asynchronous reset with two beats in flight
    send(1'b1, lo12(12'h9A5), lo12(12'h000), 11'h001);
    drain(20);
    chk("sticky_pre_reset", W'(err_sticky), W'(1'b1));
    out_ready = 1'b0;
    send_model(1'b1, lo12(12'h456));
    send_model(1'b0, lo12(12'h0A3));
    in_valid = 1'b0;
    chk("pre_reset_valid", W'(out_valid), W'(1'b1));
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid", W'(out_valid), W'(1'b0));
    chk("async_out_data", out_data, '0);
    chk("async_sticky", W'(err_sticky), W'(1'b0));
    chk("async_in_ready", W'(in_ready), W'(1'b0));
    sb.delete(); stall_prev = 1'b0; chk_rdy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("ready_at_release2", W'(in_ready), W'(1'b0));
    @(posedge clk); #1;
    chk("ready_after_release2", W'(in_ready), W'(1'b1));
    chk_rdy = 1'b1; out_ready = 1'b1;
    repeat (8) step();
    send(1'b0, lo12(12'h0A3), lo12(12'h123), 11'h000);
    drain(20);
    chk("sticky_post_reset", W'(err_sticky), W'(1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
